// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers software-written bytes in a circular FIFO and
// hands them to the UART transmitter one at a time. For each byte it issues
// a single-cycle start pulse and then follows the transmitter busy flag
// until the byte is finished.
module uart_tx_scheduler #(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   clr_flags,
  input  logic                   tx_status,
  output logic [7:0]             tx_data,
  output logic                   tx_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   sent,
  output logic                   overflow,
  output logic                   tx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          sent_q, sent_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic          full_w, empty_w, push, pop;

  // A full FIFO refuses pushes even if a pop happens in the same cycle, and
  // a pop is only taken from IDLE once the transmitter is free.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign push    = wr_en && !full_w;
  assign pop     = (state_q == IDLE) && !empty_w && !tx_status;

  // Next-state computation for FIFO bookkeeping, sticky flags and the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = 1'b0;
    sent_d     = 1'b0;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;

    if (clr_flags) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (wr_en && full_w) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_en_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        timer_d = TW'(BUSY_TIMEOUT);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_status) begin
          state_d = WAIT_DONE;
        end else if (timer_q <= TW'(1)) begin
          timer_d   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_status) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register all control state; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      sent_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      sent_q     <= sent_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // FIFO storage needs no reset; occupancy is governed by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign sent       = sent_q;
  assign overflow   = overflow_q;
  assign tx_timeout = timeout_q;

endmodule
